// File: rtl/pipelined_rca.sv
// pipelined_rca: segmented ripple-carry adder/subtractor, one register stage per SEG-bit carry segment, valid/ready handshake.
module pipelined_rca #(
  parameter int WIDTH = 16,
  parameter int SEG = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NSEG = WIDTH / SEG;
  localparam int L = NSEG - 1;
  if (WIDTH % SEG != 0) begin : g_bad_seg
    $error("WIDTH must be a multiple of SEG");
  end
  logic [NSEG-1:0][WIDTH-1:0] a_q, b_q, s_q, sa, sb, ss, ns;
  logic [NSEG-1:0] v_q, c_q, sc, nc;
  logic ovf_q, ovf_n, stall;
  assign out_valid = v_q[L];
  assign sum = s_q[L];
  assign cout = c_q[L];
  assign ovf = ovf_q;
  assign stall = out_valid & ~out_ready;
  assign in_ready = ~stall;
  // Stage k adds segment k; upper operand segments and finished lower sum segments ride along.
  always_comb begin
    sa[0] = a;
    sb[0] = sub ? ~b : b;
    sc[0] = cin ^ sub;
    ss[0] = '0;
    for (int k = 1; k < NSEG; k++) begin
      sa[k] = a_q[k-1];
      sb[k] = b_q[k-1];
      sc[k] = c_q[k-1];
      ss[k] = s_q[k-1];
    end
    ns = ss;
    nc = '0;
    for (int k = 0; k < NSEG; k++)
      {nc[k], ns[k][k*SEG +: SEG]} = {1'b0, sa[k][k*SEG +: SEG]} + {1'b0, sb[k][k*SEG +: SEG]} + (SEG+1)'(sc[k]);
    ovf_n = sa[L][WIDTH-1] ^ sb[L][WIDTH-1] ^ ns[L][WIDTH-1] ^ nc[L];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q <= '0;
      c_q <= '0;
      a_q <= '0;
      b_q <= '0;
      s_q <= '0;
      ovf_q <= 1'b0;
    end else if (!stall) begin
      v_q[0] <= in_valid;
      for (int k = 1; k < NSEG; k++) v_q[k] <= v_q[k-1];
      c_q <= nc;
      a_q <= sa;
      b_q <= sb;
      s_q <= ns;
      ovf_q <= ovf_n;
    end
  end
endmodule

// File: doc/pipelined_rca.md
Name: pipelined_rca

Overview:
- Parametrised, pipelined ripple-carry adder/subtractor.
- Splits a WIDTH-bit add into WIDTH/SEG carry segments, one register stage per segment, so WIDTH can grow without lengthening the critical path.
- Adds a subtract mode, a signed-overflow flag and a valid/ready handshake with backpressure.
- Sits between operand-producing counters/datapath and any consumer of wide arithmetic results.

Parameters:
- WIDTH, 16, operand and result width in bits.
- SEG, 4, bits per pipeline segment. WIDTH % SEG must be 0, otherwise elaboration fails. NSEG = WIDTH/SEG.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) / borrow-in (sub).
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of MSB. In subtract mode, 1 = no borrow.
- ovf  output  1  two's-complement overflow.

Behaviour:
- Reset: when rst_n=0 at a rising edge, all stage valid bits clear.
  - After that edge: out_valid=0, sum=0, cout=0, ovf=0, in_ready=1.
  - Stage data registers are cleared as well.
- Reset mid-operation: in-flight operations are discarded, never emitted. Inputs are ignored while rst_n=0.
- Arithmetic:
  - Add: a + b + cin.
  - Subtract: a + ~b + ~cin, i.e. a - b - cin.
  - {cout, sum} is the WIDTH+1-bit result.
  - ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
- Pipeline structure:
  - Stage k (0..NSEG-1) adds segment k (bits k*SEG+SEG-1 : k*SEG) of a and effective b, using the carry registered by stage k-1. Stage 0 uses the effective cin.
  - Each stage registers its partial sum, its carry and its valid bit.
  - Not-yet-consumed upper operand segments are delayed alongside.
  - Completed lower sum segments travel with the data.
- Transfers: an input transfer occurs at an edge where in_valid && in_ready. An output transfer occurs where out_valid && out_ready.
- Latency: an operand pair transferred at edge N appears on out_valid/sum/cout/ovf after edge N+NSEG-1, provided there is no stall. That is NSEG register stages. Throughput is one operation per cycle.
- Stall:
  - stall = out_valid && !out_ready.
  - While stalled, every stage holds its contents and in_ready = 0.
  - in_ready = !stall, purely combinational from the output stage.
  - Bubbles are not compressed during a stall.
- Output stability: outputs are held stable while out_valid=1 and out_ready=0.
- No-op cycle: with in_valid=0 and no stall, a bubble (valid=0) enters stage 0.
- Simultaneous events: an input and an output transfer may occur on the same edge. No data is lost or duplicated. Order is strictly FIFO.
- Result fields when out_valid=0: sum/cout/ovf may hold stale data. They are zero only after reset.
- Wrap-around: sum wraps modulo 2^WIDTH. Carry/borrow is reported only through cout.

Test Plan (WIDTH=16, SEG=4):
1. Reset: hold rst_n=0 for 2 cycles with in_valid=1, a=0x1234 -> out_valid=0, sum=0x0000, cout=0, ovf=0, in_ready=1 throughout. Nothing emerges after release.
2. Full carry ripple: a=0xFFFF, b=0x0001, cin=0, sub=0 -> sum=0x0000, cout=1, ovf=0, out_valid high exactly NSEG=4 stages after the accept edge. Also a=0xFFFE, b=0, cin=1 -> sum=0xFFFF, cout=0.
3. Signed overflow:
   - a=0x7FFF, b=0x0001, add -> sum=0x8000, ovf=1, cout=0.
   - a=0x8000, b=0x8000, add -> sum=0x0000, cout=1, ovf=1.
4. Subtract:
   - a=0x0005, b=0x0007, cin=0, sub=1 -> sum=0xFFFE, cout=0, ovf=0.
   - a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
   - a=0x0010, b=0x0003, cin=1, sub=1 -> sum=0x000C.
5. Streaming with backpressure:
   - 8 random back-to-back ops with out_ready=1 -> 8 correct results in order, one per cycle.
   - Then drop out_ready for 3 cycles while in_valid=1 -> in_ready=0, outputs frozen.
   - On release, no result is lost or duplicated (scoreboard against reference model).
6. Reset mid-stream: 3 ops in flight, assert rst_n=0 for 1 edge -> out_valid=0 after that edge. None of the 3 results ever appear. A new op accepted next cycle returns its correct result with the normal latency.
